// File: rtl/calc_pkg.sv
// Shared widths, opcode/state encodings and flag bit indices for the calculator tile.
// Build option CALC_DIV_EN adds the iterative divider (DIV/MOD); without it those ops are illegal.
package calc_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned OP_W       = 4;
   localparam int unsigned ITER       = 16;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned FLAG_ERR   = 1;
   localparam int unsigned FLAG_CARRY = 0;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SHL = 4'd5,
      OP_SHR = 4'd6,
      OP_MUL = 4'd7,
      OP_DIV = 4'd8,
      OP_MOD = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_OUT_HI,
      ST_OUT_LO
   } state_t;

   // Ops that run the 16-step iterative unit instead of the single-cycle ALU.
   function automatic logic is_iter_op(input logic [OP_W-1:0] o);
`ifdef CALC_DIV_EN
      return (o == OP_MUL) || (o == OP_DIV) || (o == OP_MOD);
`else
      return (o == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/calc_iter.sv
// Iterative 16-step shift-add multiplier and (with CALC_DIV_EN) restoring divider.
// Both share one 32-bit accumulator: {high/remainder, low/quotient}.
module calc_iter
   import calc_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
`ifdef CALC_DIV_EN
   input  logic              div_i,
   input  logic              rem_i,
`endif
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              hi_nz_o,
   output logic              dbz_o
);

   logic [2*DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]   opnd_q, opnd_d;
   logic [DATA_W:0]     mul_sum;
`ifdef CALC_DIV_EN
   logic                div_q, div_d;
   logic                rem_q, rem_d;
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     trial;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         opnd_q <= '0;
`ifdef CALC_DIV_EN
         div_q  <= 1'b0;
         rem_q  <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
`ifdef CALC_DIV_EN
         div_q  <= div_d;
         rem_q  <= rem_d;
`endif
      end
   end

   always_comb begin
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
`ifdef CALC_DIV_EN
      div_d   = div_q;
      rem_d   = rem_q;
      // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
      shifted = acc_q[2*DATA_W-1:DATA_W-1];
      trial   = shifted - {1'b0, opnd_q};
      if (load_i) begin
         div_d = div_i;
         rem_d = rem_i;
         if (div_i) begin
            acc_d  = {{DATA_W{1'b0}}, a_i};
            opnd_d = b_i;
         end else begin
            acc_d  = {{DATA_W{1'b0}}, b_i};
            opnd_d = a_i;
         end
      end else if (step_i) begin
         if (div_q) begin
            if (!trial[DATA_W])
               acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            else
               acc_d = {shifted[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
         end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
         end
      end
`else
      if (load_i) begin
         acc_d  = {{DATA_W{1'b0}}, b_i};
         opnd_d = a_i;
      end else if (step_i) begin
         acc_d = {mul_sum, acc_q[DATA_W-1:1]};
      end
`endif
   end

`ifdef CALC_DIV_EN
   assign result_o = (div_q && rem_q) ? acc_q[2*DATA_W-1:DATA_W] : acc_q[DATA_W-1:0];
   assign dbz_o    = div_q && (opnd_q == '0);
`else
   assign result_o = acc_q[DATA_W-1:0];
   assign dbz_o    = 1'b0;
`endif
   assign hi_nz_o  = |acc_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/calc_sequencer.sv
// Calculator tile sequencer: accepts an operand pair + opcode, runs the ALU or iterative unit,
// and returns the 16-bit result high byte first over valid/ack. CALC_DIV_EN enables DIV/MOD.
module calc_sequencer
   import calc_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] num1,
   input  logic [DATA_W-1:0] num2,
   input  logic [OP_W-1:0]   op,
   input  logic              start,
   input  logic              ack,
   output logic [7:0]        out,
   output logic              out_valid,
   output logic [1:0]        flags,
   output logic              busy
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, b_q;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] res_q, res_d, alu_res, iter_res, res_out;
   logic [1:0]        flg_q, flg_d, alu_flg, flg_out;
   logic [DATA_W:0]   add_w, sub_w;
   logic              accept, iter_op, step, hi_nz, dbz;

   assign accept  = (state_q == ST_IDLE) && start;
   assign iter_op = is_iter_op(op_q);
   assign step    = (state_q == ST_EXEC) && iter_op;

   calc_iter u_iter (
      .clk_i    (clock),
      .rst_i    (reset),
      .load_i   (accept),
      .step_i   (step),
`ifdef CALC_DIV_EN
      .div_i    ((op == OP_DIV) || (op == OP_MOD)),
      .rem_i    (op == OP_MOD),
`endif
      .a_i      (num1),
      .b_i      (num2),
      .result_o (iter_res),
      .hi_nz_o  (hi_nz),
      .dbz_o    (dbz)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         cnt_q <= '0;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         if (accept) begin
            a_q  <= num1;
            b_q  <= num2;
            op_q <= op;
         end
         cnt_q <= cnt_d;
         res_q <= res_d;
         flg_q <= flg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_EXEC;
         ST_EXEC:   if (!iter_op || (cnt_q == CNT_LAST)) state_d = ST_OUT_HI;
         ST_OUT_HI: if (ack) state_d = ST_OUT_LO;
         ST_OUT_LO: if (ack) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept)    cnt_d = '0;
      else if (step) cnt_d = cnt_q + 1'b1;
   end

   // Single-cycle ALU; borrow of the 17-bit subtract is exactly A<B.
   always_comb begin
      add_w   = {1'b0, a_q} + {1'b0, b_q};
      sub_w   = {1'b0, a_q} - {1'b0, b_q};
      alu_res = '0;
      alu_flg = '0;
      case (op_q)
         OP_ADD: begin alu_res = add_w[DATA_W-1:0]; alu_flg[FLAG_CARRY] = add_w[DATA_W]; end
         OP_SUB: begin alu_res = sub_w[DATA_W-1:0]; alu_flg[FLAG_CARRY] = sub_w[DATA_W]; end
         OP_AND: alu_res = a_q & b_q;
         OP_OR:  alu_res = a_q | b_q;
         OP_XOR: alu_res = a_q ^ b_q;
         OP_SHL: alu_res = a_q << b_q[3:0];
         OP_SHR: alu_res = a_q >> b_q[3:0];
         default: alu_flg[FLAG_ERR] = 1'b1;
      endcase
      res_d = res_q;
      flg_d = flg_q;
      if ((state_q == ST_EXEC) && !iter_op) begin
         res_d = alu_res;
         flg_d = alu_flg;
      end
   end

   // Iterative results are read straight from the unit, which holds still once stepping ends.
   always_comb begin
      res_out = res_q;
      flg_out = flg_q;
      if (iter_op) begin
         flg_out = '0;
         if (dbz) begin
            res_out            = '1;
            flg_out[FLAG_ERR]  = 1'b1;
         end else begin
            res_out              = iter_res;
            flg_out[FLAG_CARRY]  = (op_q == OP_MUL) && hi_nz;
         end
      end
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      out_valid = (state_q == ST_OUT_HI) || (state_q == ST_OUT_LO);
      out       = '0;
      if (state_q == ST_OUT_HI)      out = res_out[DATA_W-1:8];
      else if (state_q == ST_OUT_LO) out = res_out[7:0];
      flags     = out_valid ? flg_out : '0;
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; edge N is the edge just before start is raised,
// so start is sampled at N+1. DIV/MOD expectations follow the CALC_DIV_EN build option.
module tb_calc_sequencer;
   import calc_pkg::*;

   logic        clock = 1'b0;
   logic        reset, start, ack;
   logic [15:0] num1, num2;
   logic [3:0]  op;
   logic [7:0]  out;
   logic        out_valid, busy;
   logic [1:0]  flags;

   int checks = 0;
   int errors = 0;

   calc_sequencer dut (
      .clock     (clock),
      .reset     (reset),
      .num1      (num1),
      .num2      (num2),
      .op        (op),
      .start     (start),
      .ack       (ack),
      .out       (out),
      .out_valid (out_valid),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction with ack held high; lat = edges from N until out_valid is seen.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input int unsigned lat,
                         input logic [15:0] exp_res, input logic [1:0] exp_flg, input bit inj);
      num1 = a; num2 = b; op = o; start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; num1 = 16'hDEAD; num2 = 16'hBEEF; op = 4'd0;
      chk({tag, "_busy_exec"}, busy, 16'd1);
      chk({tag, "_valid_exec"}, out_valid, 16'd0);
      for (int i = 2; i < lat; i++) begin
         if (inj && i == 2) begin
            start = 1'b1; op = 4'd0; num1 = 16'hAAAA; num2 = 16'h5555;
         end
         tick();
         start = 1'b0;
      end
      chk({tag, "_valid_pre"}, out_valid, 16'd0);
      tick();
      chk({tag, "_valid_hi"}, out_valid, 16'd1);
      chk({tag, "_hi"}, out, exp_res[15:8]);
      chk({tag, "_flags_hi"}, flags, exp_flg);
      tick();
      chk({tag, "_valid_lo"}, out_valid, 16'd1);
      chk({tag, "_lo"}, out, exp_res[7:0]);
      chk({tag, "_flags_lo"}, flags, exp_flg);
      tick();
      chk({tag, "_busy_done"}, busy, 16'd0);
      chk({tag, "_valid_done"}, out_valid, 16'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; ack = 1'b0;
      num1 = '0; num2 = '0; op = '0;
      tick();
      tick();
      chk("rst_out", out, 16'h0000);
      chk("rst_valid", out_valid, 16'd0);
      chk("rst_flags", flags, 16'd0);
      chk("rst_busy", busy, 16'd0);
      reset = 1'b0;

      run_op("add", 4'd0, 16'h1234, 16'h0F0F, 2, 16'h2143, 2'b00, 1'b0);
      run_op("sub", 4'd1, 16'h0001, 16'h0002, 2, 16'hFFFF, 2'b01, 1'b0);
      run_op("xor", 4'd4, 16'hF0F0, 16'h0FF0, 2, 16'hFF00, 2'b00, 1'b0);
      run_op("shl", 4'd5, 16'h0001, 16'h000F, 2, 16'h8000, 2'b00, 1'b0);
      run_op("shr", 4'd6, 16'h8000, 16'h0013, 2, 16'h1000, 2'b00, 1'b0);
      run_op("ill", 4'hF, 16'h1234, 16'h5678, 2, 16'h0000, 2'b10, 1'b0);
      run_op("mul", 4'd7, 16'h00FF, 16'h0003, 17, 16'h02FD, 2'b00, 1'b0);
      run_op("mul_ovf", 4'd7, 16'h0100, 16'h0100, 17, 16'h0000, 2'b01, 1'b0);
      run_op("mul_inj", 4'd7, 16'h00FF, 16'h0003, 17, 16'h02FD, 2'b00, 1'b1);
`ifdef CALC_DIV_EN
      run_op("div", 4'd8, 16'h0064, 16'h0007, 17, 16'h000E, 2'b00, 1'b0);
      run_op("mod", 4'd9, 16'h0064, 16'h0007, 17, 16'h0002, 2'b00, 1'b0);
      run_op("div0", 4'd8, 16'h0064, 16'h0000, 17, 16'hFFFF, 2'b10, 1'b0);
`else
      run_op("div_off", 4'd8, 16'h0064, 16'h0007, 2, 16'h0000, 2'b10, 1'b0);
      run_op("mod_off", 4'd9, 16'h0064, 16'h0007, 2, 16'h0000, 2'b10, 1'b0);
`endif

      // Stall in both output bytes; each byte needs its own ack edge.
      num1 = 16'h1234; num2 = 16'h0F0F; op = 4'd0; start = 1'b1; ack = 1'b0;
      tick();
      start = 1'b0;
      tick();
      chk("stall_hi0", out, 16'h0021);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_hi", out, 16'h0021);
         chk("stall_valid", out_valid, 16'd1);
         chk("stall_flags", flags, 16'd0);
      end
      ack = 1'b1;
      tick();
      chk("stall_lo", out, 16'h0043);
      ack = 1'b0;
      tick();
      chk("stall_lo_hold", out, 16'h0043);
      chk("stall_lo_busy", busy, 16'd1);
      ack = 1'b1;
      tick();
      chk("stall_done", busy, 16'd0);

      // Reset while the multiplier counter sits at 7.
      num1 = 16'h0100; num2 = 16'h0100; op = 4'd7; start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("rmid_busy_pre", busy, 16'd1);
      reset = 1'b1;
      tick();
      chk("rmid_busy", busy, 16'd0);
      chk("rmid_valid", out_valid, 16'd0);
      chk("rmid_out", out, 16'h0000);
      chk("rmid_flags", flags, 16'd0);
      reset = 1'b0;
      run_op("add_after_rst", 4'd0, 16'h1234, 16'h0F0F, 2, 16'h2143, 2'b00, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
